// File: rtl/mul32_seq.sv
// Sequential 32x32->64 shift-add multiplier (signed/unsigned) built around one shared cla64.
// Latency: 32 cycles from accept to out_valid, 33 when the product must be negated.
// Backpressure: in_ready only in IDLE; the product is held in DONE until out_ready.

module cla64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum
);
  // Two-level lookahead: 4-bit groups, 16-bit blocks; top bit needs no generate term.
  logic [63:0] prop;
  logic [62:0] gen;
  logic [63:0] carry;
  logic [14:0] grp_gen;
  logic [14:0] grp_prop;
  logic [15:0] grp_carry;
  logic [2:0]  blk_gen;
  logic [2:0]  blk_prop;
  logic [3:0]  blk_carry;

  function automatic logic grp_g4(input logic [3:0] g, input logic [2:0] p_hi);
    return g[3] | (p_hi[2] & g[2]) | (p_hi[2] & p_hi[1] & g[1]) |
           (p_hi[2] & p_hi[1] & p_hi[0] & g[0]);
  endfunction

  function automatic logic [3:0] carries4(input logic [2:0] g, input logic [2:0] p,
                                          input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  assign prop = a ^ b;
  assign gen  = a[62:0] & b[62:0];

  always_comb begin
    grp_gen   = '0;
    grp_prop  = '0;
    blk_gen   = '0;
    blk_prop  = '0;
    blk_carry = '0;
    grp_carry = '0;
    carry     = '0;
    for (int i = 0; i < 15; i++) begin
      grp_gen[i]  = grp_g4(gen[4*i +: 4], prop[4*i+1 +: 3]);
      grp_prop[i] = &prop[4*i +: 4];
    end
    for (int j = 0; j < 3; j++) begin
      blk_gen[j]  = grp_g4(grp_gen[4*j +: 4], grp_prop[4*j+1 +: 3]);
      blk_prop[j] = &grp_prop[4*j +: 4];
    end
    blk_carry = carries4(blk_gen, blk_prop, cin);
    for (int j = 0; j < 4; j++) begin
      grp_carry[4*j +: 4] = carries4(grp_gen[4*j +: 3], grp_prop[4*j +: 3], blk_carry[j]);
    end
    for (int i = 0; i < 16; i++) begin
      carry[4*i +: 4] = carries4(gen[4*i +: 3], prop[4*i +: 3], grp_carry[i]);
    end
  end

  assign sum = prop ^ carry;
endmodule

module mul32_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] p
);
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [4:0]  cnt;
  logic        neg;
  logic        fix_sel;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic [63:0] add_sum;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag_a = (sgn & a[31]) ? (~a + 32'd1) : a;
  assign mag_b = (sgn & b[31]) ? (~b + 32'd1) : b;

  // The one adder either accumulates or forms ~acc+1 for the sign fix.
  assign add_a = fix_sel ? ~acc : acc;
  assign add_b = fix_sel ? 64'd0 : mcand;

  cla64 u_cla64 (
    .a   (add_a),
    .b   (add_b),
    .cin (fix_sel),
    .sum (add_sum)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    fix_sel    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = BUSY;
      end
      BUSY: begin
        if (cnt == 5'd31) next_state = neg ? FIX : DONE;
      end
      FIX: begin
        fix_sel    = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {32'b0, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= sgn & (a[31] ^ b[31]);
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= add_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        FIX: acc <= add_sum;
        default: ;
      endcase
    end
  end

  assign p = acc;
endmodule

// File: tb/tb_mul32_seq.sv
// Scoreboarded bench for mul32_seq: directed corner products, backpressure, mid-op reset, random ops.
module tb_mul32_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] p;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb[$];

  mul32_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic op_sgn, input int hold);
    int lat;
    int exp_lat;
    logic [63:0] exp_p;
    check({tag, "_in_ready_idle"}, {63'b0, in_ready}, 64'd1);
    a         = op_a;
    b         = op_b;
    sgn       = op_sgn;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    sb.push_back(model(op_a, op_b, op_sgn));
    exp_lat = 32 + int'(op_sgn & (op_a[31] ^ op_b[31]));
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    sgn      = $urandom_range(0, 1);
    lat      = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    exp_p = 64'hDEAD_BEEF_DEAD_BEEF;
    if (sb.size() > 0) exp_p = sb.pop_front();
    check({tag, "_p"}, p, exp_p);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        in_valid = $urandom_range(0, 1);
        a        = $urandom;
        b        = $urandom;
        check({tag, "_hold_p"}, p, exp_p);
        check({tag, "_hold_in_ready"}, {63'b0, in_ready}, 64'd0);
        check({tag, "_hold_out_valid"}, {63'b0, out_valid}, 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_in_ready_after"}, {63'b0, in_ready}, 64'd1);
    check({tag, "_out_valid_after"}, {63'b0, out_valid}, 64'd0);
    check({tag, "_p_after"}, p, exp_p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    a         = 32'd3;
    b         = 32'd5;
    sgn       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_p", p, 64'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;

    run_op("u_small", 32'd3, 32'd5, 1'b0, 0);
    run_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("s_neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 0);
    run_op("s_neg1x0", 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    run_op("s_extreme", 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    run_op("s_mixed", 32'h8000_0000, 32'd1, 1'b1, 0);
    run_op("backpressure", 32'd5, 32'hFFFF_FFFD, 1'b1, 10);

    // Reset at the 10th BUSY cycle discards the product in flight.
    a        = 32'd7;
    b        = 32'd9;
    sgn      = 1'b0;
    in_valid = 1'b1;
    sb.push_back(model(32'd7, 32'd9, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_p", p, 64'd0);
    run_op("after_rst", 32'd6, 32'd7, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      run_op("random", $urandom, $urandom, 1'($urandom_range(0, 1)), (i % 5 == 4) ? 3 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul32_seq.md
# mul32_seq

Sequential 32x32 shift-add multiplier that drives the team's 64-bit carry-lookahead adder, `cla64`, and consumes its result. It instantiates exactly one `cla64` (ports a, b, cin, sum) and uses it for partial-product accumulation and the final two's-complement sign fix. It sits between the operand-issue logic and the result writeback, with valid/ready handshakes on both sides, and supports unsigned and signed operands.

## Interface
- No parameters. Width is fixed at 32x32->64.
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset_n`  in  1  reset: synchronous, active-low
- `in_valid`  in  1  operands presented
- `in_ready`  out  1  block can accept operands; high only in IDLE
- `a`  in  32  multiplicand
- `b`  in  32  multiplier
- `sgn`  in  1  1 = signed two's-complement operands, 0 = unsigned
- `out_valid`  out  1  `p` holds a completed product
- `out_ready`  in  1  consumer takes `p`
- `p`  out  64  product register

## Operation
- **States:** IDLE, BUSY, FIX, DONE. `in_ready = (state==IDLE)`. `out_valid = (state==DONE)`. `p` is the accumulator register `acc`.
- **Accept** (IDLE, `in_valid & in_ready`): operands are sampled only at this edge. The block loads:
  - `mcand` = {32'b0, |a|}, 64-bit
  - `mplier` = |b|, 32-bit
  - `acc` = 0, `cnt` = 0
  - `neg` = `sgn & (a[31]^b[31])`
  - state goes to BUSY.
- **Magnitudes:** |x| = x when `sgn=0` or x[31]=0; otherwise ~x+1, truncated to 32 bits unsigned. 0x80000000 maps to 0x80000000.
- **BUSY, each cycle:**
  - If `mplier[0]`, `acc <= cla64(acc, mcand, cin=0)`; else `acc` holds.
  - Then `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
  - On the cycle with `cnt==31`, the next state is FIX if `neg`, else DONE.
- **FIX, one cycle:** `acc <= cla64(~acc, 64'b0, cin=1)`, then state goes to DONE.
- **DONE:**
  - `p` is held stable while `out_ready=0`.
  - On `out_ready=1`, state goes to IDLE and `acc` keeps its value, so `p` still shows the last product.
- There is no early termination; latency is data-independent except for FIX.
- Arithmetic is modulo 2^64. The unsigned maximum 0xFFFFFFFF^2 and the signed extreme (-2^31)^2 both fit, so no overflow flag exists.
- `in_valid`, `a`, `b` and `sgn` are ignored outside IDLE.

## Timing
- **Reset:** at the first rising edge with `reset_n=0`, the block enters:
  - state = IDLE, `acc` = 0, `mcand` = 0, `mplier` = 0, `cnt` = 0, `neg` = 0
  - outputs: `in_ready=1`, `out_valid=0`, `p=0`.
- Reset has priority over everything, including mid-BUSY, mid-FIX and DONE with a pending product. A product in flight is discarded with no output.
- `in_valid` sampled on a reset edge is not accepted.
- **Latency:** accept at edge k. `out_valid` rises after edge k+32 when `neg=0`, or after edge k+33 when `neg=1`.
- **Throughput:** one product per 34 or 35 cycles with `out_ready` tied high.
- **Output handshake:** the transfer occurs at an edge with `out_valid & out_ready`. `in_ready` rises the cycle after that edge. There is no same-cycle DONE->accept bypass.
- `cla64` is purely combinational within one cycle; its output is registered only into `acc`.

## Test plan
- **Unsigned small:** `sgn=0`, a=3, b=5, `out_ready=1`. Required: `out_valid` exactly 32 cycles after accept, p=0x000000000000000F, then `in_ready=1` the next cycle.
- **Unsigned max:** a=b=0xFFFFFFFF, `sgn=0`. Required: p=0xFFFFFFFE00000001 at 32-cycle latency.
- **Signed, one negative:** `sgn=1`, a=0xFFFFFFFD (-3), b=5. Required: FIX is taken, latency 33, p=0xFFFFFFFFFFFFFFF1. Also `sgn=1`, a=0xFFFFFFFF, b=0 gives p=0 at latency 33.
- **Signed extreme:** `sgn=1`, a=b=0x80000000. Required: `neg=0`, latency 32, p=0x4000000000000000.
- **Backpressure:** `out_ready=0` for 10 cycles in DONE, with `a`, `b` and `in_valid` toggling meanwhile. Required: p stable, `in_ready=0` throughout. Raise `out_ready`; the next cycle shows `in_ready=1`, `out_valid=0`, p unchanged.
- **Reset mid-operation:** start a=7, b=9, then drive `reset_n=0` for one edge at the 10th BUSY cycle. Required: the next cycle shows `in_ready=1`, `out_valid=0`, p=0. A new op, a=6, b=7, then yields p=42 at latency 32.
